// File: rtl/fft_pkg.sv
// Shared FFT definitions: twiddle quadrant encoding and the quarter-wave
// cosine generator used to build the twiddle ROM at elaboration time.
package fft_pkg;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  localparam real TWO_PI = 6.283185307179586;

  function automatic int one_q(input int coef_w);
    return 1 << (coef_w - 2);
  endfunction

  // End points are forced exact so k=0 and k=N/4 carry no table error.
  function automatic int cos_q(input int r, input int log2n,
                               input int coef_w);
    real ang;
    real v;
    int  n;
    n = 1 << log2n;
    if (r == 0) return one_q(coef_w);
    if (4 * r >= n) return 0;
    ang = TWO_PI * real'(r) / real'(n);
    v = $cos(ang) * real'(one_q(coef_w));
    return $rtoi(v + 0.5);
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Quarter-wave cosine table, N/4+1 entries, two synchronous read ports.
// Contents come from fft_pkg::cos_q; no reset on the read registers.
module twiddle_rom
  import fft_pkg::*;
#(
  parameter int LOG2N  = 3,
  parameter int COEF_W = 18,
  parameter int AW     = LOG2N - 1
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [AW-1:0]            addr_a,
  input  logic [AW-1:0]            addr_b,
  output logic signed [COEF_W-1:0] rd_a,
  output logic signed [COEF_W-1:0] rd_b
);

  localparam int NQ = 1 << (LOG2N - 2);

  logic signed [COEF_W-1:0] tab [NQ+1];
  logic signed [COEF_W-1:0] rd_a_d, rd_a_q;
  logic signed [COEF_W-1:0] rd_b_d, rd_b_q;

  for (genvar g = 0; g <= NQ; g++) begin : g_tab
    localparam int V = cos_q(g, LOG2N, COEF_W);
    assign tab[g] = COEF_W'(V);
  end

  always_comb begin
    rd_a_d = rd_a_q;
    rd_b_d = rd_b_q;
    if (en) begin
      rd_a_d = tab[addr_a];
      rd_b_d = tab[addr_b];
    end
  end

  always_ff @(posedge clk) begin
    rd_a_q <= rd_a_d;
    rd_b_q <= rd_b_d;
  end

  assign rd_a = rd_a_q;
  assign rd_b = rd_b_q;

endmodule

// File: rtl/twiddle_rotator_pipe.sv
// 4-stage complex rotator by e^{-/+j*2*pi*k/N} with valid/ready and saturation.
// Define TWIDDLE_ROUND_EN for round-half-up; otherwise truncation toward -inf.
module twiddle_rotator_pipe
  import fft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 3,
  parameter int COEF_W = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [DATA_W-1:0] in_q,
  input  logic [LOG2N-1:0]         in_k,
  input  logic                     in_inv,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_m_i,
  output logic signed [DATA_W-1:0] out_m_q,
  output logic signed [DATA_W-1:0] out_p_i,
  output logic signed [DATA_W-1:0] out_p_q
);

  localparam int P  = DATA_W + COEF_W;
  localparam int S  = P + 1;
  localparam int SH = COEF_W - 2;
  localparam int RW = (LOG2N > 2) ? LOG2N - 2 : 1;
  localparam int AW = LOG2N - 1;
  localparam int NQ = 1 << (LOG2N - 2);
  localparam logic [RW-1:0] RMASK = {RW{LOG2N > 2}};
  localparam longint MAXL = (longint'(1) << (DATA_W - 1)) - 1;
  localparam logic signed [S-1:0] MAXV = S'(MAXL);
  localparam logic signed [S-1:0] MINV = S'(-MAXL - 1);
`ifdef TWIDDLE_ROUND_EN
  localparam logic signed [S-1:0] RND = S'(longint'(1) << (COEF_W - 3));
`else
  localparam logic signed [S-1:0] RND = '0;
`endif

  if (LOG2N < 2) begin : g_bad_log2n
    $error("twiddle_rotator_pipe: LOG2N must be >= 2");
  end

  function automatic logic signed [DATA_W-1:0] rss(
    input logic signed [S-1:0] v);
    logic signed [S-1:0] t;
    t = (v + RND) >>> SH;
    if (t > MAXV) t = MAXV;
    if (t < MINV) t = MINV;
    return DATA_W'(t);
  endfunction

  logic ce;

  logic                     v1_d, v1_q, inv1_d, inv1_q;
  logic signed [DATA_W-1:0] a1_d, a1_q, b1_d, b1_q;
  logic [1:0]               q1_d, q1_q;
  logic [RW-1:0]            r1_d, r1_q;

  logic                     v2_d, v2_q, inv2_d, inv2_q;
  logic signed [DATA_W-1:0] a2_d, a2_q, b2_d, b2_q;
  logic [1:0]               q2_d, q2_q;
  logic [AW-1:0]            addr_a, addr_b;
  logic signed [COEF_W-1:0] cos_a, cos_b, c, s;

  logic                v3_d, v3_q, inv3_d, inv3_q;
  logic signed [P-1:0] ac_d, ac_q, bs_d, bs_q;
  logic signed [P-1:0] bc_d, bc_q, as_d, as_q;

  logic                     v4_d, v4_q;
  logic signed [S-1:0]      mi, mq, pi, pq;
  logic signed [DATA_W-1:0] om_i_d, om_i_q, om_q_d, om_q_q;
  logic signed [DATA_W-1:0] op_i_d, op_i_q, op_q_d, op_q_q;

  assign ce       = !v4_q || out_ready;
  assign in_ready = ce;

  assign addr_a = AW'(r1_q);
  assign addr_b = AW'(NQ) - AW'(r1_q);

  twiddle_rom #(
    .LOG2N (LOG2N),
    .COEF_W(COEF_W),
    .AW    (AW)
  ) u_rom (
    .clk   (clk),
    .en    (ce),
    .addr_a(addr_a),
    .addr_b(addr_b),
    .rd_a  (cos_a),
    .rd_b  (cos_b)
  );

  // Rotate the first-quadrant pair into the sample's quadrant.
  always_comb begin
    c = cos_a;
    s = cos_b;
    unique case (q2_q)
      QUAD_0: begin c = cos_a;  s = cos_b;  end
      QUAD_1: begin c = -cos_b; s = cos_a;  end
      QUAD_2: begin c = -cos_a; s = -cos_b; end
      QUAD_3: begin c = cos_b;  s = -cos_a; end
    endcase
  end

  always_comb begin
    mi = S'(ac_q) + S'(bs_q);
    mq = S'(bc_q) - S'(as_q);
    pi = S'(ac_q) - S'(bs_q);
    pq = S'(bc_q) + S'(as_q);
  end

  always_comb begin
    v1_d = v1_q; inv1_d = inv1_q;
    a1_d = a1_q; b1_d = b1_q;
    q1_d = q1_q; r1_d = r1_q;
    v2_d = v2_q; inv2_d = inv2_q;
    a2_d = a2_q; b2_d = b2_q; q2_d = q2_q;
    v3_d = v3_q; inv3_d = inv3_q;
    ac_d = ac_q; bs_d = bs_q;
    bc_d = bc_q; as_d = as_q;
    v4_d = v4_q;
    om_i_d = om_i_q; om_q_d = om_q_q;
    op_i_d = op_i_q; op_q_d = op_q_q;
    if (ce) begin
      v1_d   = in_valid;
      inv1_d = in_inv;
      a1_d   = in_i;
      b1_d   = in_q;
      q1_d   = in_k[LOG2N-1 -: 2];
      r1_d   = RW'(in_k) & RMASK;
      v2_d   = v1_q;
      inv2_d = inv1_q;
      a2_d   = a1_q;
      b2_d   = b1_q;
      q2_d   = q1_q;
      v3_d   = v2_q;
      inv3_d = inv2_q;
      ac_d   = a2_q * c;
      bs_d   = b2_q * s;
      bc_d   = b2_q * c;
      as_d   = a2_q * s;
      v4_d   = v3_q;
      om_i_d = inv3_q ? rss(pi) : rss(mi);
      om_q_d = inv3_q ? rss(pq) : rss(mq);
      op_i_d = inv3_q ? rss(mi) : rss(pi);
      op_q_d = inv3_q ? rss(mq) : rss(pq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0; inv1_q <= 1'b0;
      a1_q <= '0; b1_q <= '0;
      q1_q <= '0; r1_q <= '0;
      v2_q <= 1'b0; inv2_q <= 1'b0;
      a2_q <= '0; b2_q <= '0; q2_q <= '0;
      v3_q <= 1'b0; inv3_q <= 1'b0;
      ac_q <= '0; bs_q <= '0;
      bc_q <= '0; as_q <= '0;
      v4_q <= 1'b0;
      om_i_q <= '0; om_q_q <= '0;
      op_i_q <= '0; op_q_q <= '0;
    end else begin
      v1_q <= v1_d; inv1_q <= inv1_d;
      a1_q <= a1_d; b1_q <= b1_d;
      q1_q <= q1_d; r1_q <= r1_d;
      v2_q <= v2_d; inv2_q <= inv2_d;
      a2_q <= a2_d; b2_q <= b2_d; q2_q <= q2_d;
      v3_q <= v3_d; inv3_q <= inv3_d;
      ac_q <= ac_d; bs_q <= bs_d;
      bc_q <= bc_d; as_q <= as_d;
      v4_q <= v4_d;
      om_i_q <= om_i_d; om_q_q <= om_q_d;
      op_i_q <= op_i_d; op_q_q <= op_q_d;
    end
  end

  assign out_valid = v4_q;
  assign out_m_i   = om_i_q;
  assign out_m_q   = om_q_q;
  assign out_p_i   = op_i_q;
  assign out_p_q   = op_q_q;

endmodule
